// File: rtl/tm1638_key_reader.sv
// tm1638_key_reader: reads the four key-scan bytes from a TM1638 over STB/CLK/DIO.
// A start request sends the read-key command LSB first, then releases DIO and
// clocks in 32 scan bits. After that it publishes the raw word and the decoded
// key vector, together with a one-cycle done pulse.
// Ports:
//   clk, rst       system clock (one tm_clk half-period per cycle), async active-high reset
//   start          scan request, honoured only when idle
//   dio_in         DIO pad readback
//   tm_clk, tm_stb TM1638 CLK and STB (STB active low)
//   dio_out/dio_oe DIO drive value and drive enable (0 = released, pulled up)
//   busy, done     transfer in progress / one-cycle completion pulse
//   raw, keys      32-bit scan word (byte0 in [7:0]) and 8 decoded keys
module tm1638_key_reader #(
   parameter logic [7:0]  CMD_READ    = 8'h42,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        dio_in,
   output logic        tm_clk,
   output logic        tm_stb,
   output logic        dio_out,
   output logic        dio_oe,
   output logic        busy,
   output logic        done,
   output logic [31:0] raw,
   output logic [7:0]  keys
);

   localparam int unsigned CMD_LAST  = 15;
   localparam int unsigned READ_LAST = 63;
   localparam int unsigned CNT_W     = ($clog2(WAIT_CYCLES) > 6) ? $clog2(WAIT_CYCLES) : 6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_STB_LOW,
      S_CMD,
      S_TURN,
      S_READ,
      S_STB_HIGH
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        shift_q, shift_d;
   logic [31:0]        raw_q, raw_d;
   logic [7:0]         keys_q, keys_d;
   logic               tm_clk_q, tm_clk_d;
   logic               tm_stb_q, tm_stb_d;
   logic               dio_out_q, dio_out_d;
   logic               dio_oe_q, dio_oe_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // State, counter, data and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         raw_q     <= '0;
         keys_q    <= '0;
         tm_clk_q  <= 1'b1;
         tm_stb_q  <= 1'b1;
         dio_out_q <= 1'b1;
         dio_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         raw_q     <= raw_d;
         keys_q    <= keys_d;
         tm_clk_q  <= tm_clk_d;
         tm_stb_q  <= tm_stb_d;
         dio_out_q <= dio_out_d;
         dio_oe_q  <= dio_oe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next-state logic; outputs are then decoded from the next state so they
   // become registered values that line up with the state they belong to.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      raw_d     = raw_q;
      keys_d    = keys_q;
      done_d    = 1'b0;
      tm_clk_d  = 1'b1;
      tm_stb_d  = 1'b1;
      dio_out_d = 1'b1;
      dio_oe_d  = 1'b0;
      busy_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            // The done cycle acts as a guard cycle, so back-to-back scans keep
            // STB high for at least two cycles.
            if (start && !done_q) begin
               state_d = S_STB_LOW;
               cnt_d   = '0;
            end
         end
         S_STB_LOW: begin
            state_d = S_CMD;
            cnt_d   = '0;
         end
         S_CMD: begin
            if (cnt_q == CNT_W'(CMD_LAST)) begin
               state_d = S_TURN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_TURN: begin
            if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
               state_d = S_READ;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_READ: begin
            // Sample at the edge that ends the high phase of each bit.
            if (cnt_q[0]) begin
               shift_d[cnt_q[5:1]] = dio_in;
            end
            if (cnt_q == CNT_W'(READ_LAST)) begin
               state_d = S_STB_HIGH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STB_HIGH: begin
            state_d = S_IDLE;
            raw_d   = shift_q;
            for (int i = 0; i < 4; i++) begin
               keys_d[i]     = shift_q[8*i];
               keys_d[i + 4] = shift_q[8*i + 4];
            end
            done_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // Pin values for the cycle entered at this edge.
      case (state_d)
         S_STB_LOW: begin
            tm_stb_d  = 1'b0;
            dio_oe_d  = 1'b1;
            dio_out_d = CMD_READ[0];
            busy_d    = 1'b1;
         end
         S_CMD: begin
            tm_stb_d  = 1'b0;
            tm_clk_d  = cnt_d[0];
            dio_oe_d  = 1'b1;
            dio_out_d = CMD_READ[cnt_d[3:1]];
            busy_d    = 1'b1;
         end
         S_TURN: begin
            tm_stb_d = 1'b0;
            busy_d   = 1'b1;
         end
         S_READ: begin
            tm_stb_d = 1'b0;
            tm_clk_d = cnt_d[0];
            busy_d   = 1'b1;
         end
         S_STB_HIGH: begin
            busy_d = 1'b1;
         end
         default: ;
      endcase
   end

   assign tm_clk  = tm_clk_q;
   assign tm_stb  = tm_stb_q;
   assign dio_out = dio_out_q;
   assign dio_oe  = dio_oe_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign raw     = raw_q;
   assign keys    = keys_q;

endmodule

// File: tb/tb_tm1638_key_reader.sv
// tb_tm1638_key_reader: timeline model of the scan plus a TM1638 device model,
// with a per-cycle compare and directed scenarios with literal expectations.
module tb_tm1638_key_reader;

   localparam int unsigned W    = 2;
   localparam int unsigned W5   = 5;
   localparam int unsigned TDONE = 83 + W;   // model cycle index of the done cycle

   logic clk;
   logic rst;
   logic start;
   logic dio_in;
   logic tm_clk, tm_stb, dio_out, dio_oe, busy, done;
   logic [31:0] raw;
   logic [7:0]  keys;

   logic start5;
   logic dio_in5;
   logic tm_clk5, tm_stb5, dio_out5, dio_oe5, busy5, done5;
   logic [31:0] raw5;
   logic [7:0]  keys5;

   int tests = 0;
   int fails = 0;

   logic [7:0] cmd_byte;
   initial cmd_byte = 8'h42;

   tm1638_key_reader #(.CMD_READ(8'h42), .WAIT_CYCLES(W)) u_dut (
      .clk(clk), .rst(rst), .start(start), .dio_in(dio_in),
      .tm_clk(tm_clk), .tm_stb(tm_stb), .dio_out(dio_out), .dio_oe(dio_oe),
      .busy(busy), .done(done), .raw(raw), .keys(keys)
   );

   tm1638_key_reader #(.CMD_READ(8'h42), .WAIT_CYCLES(W5)) u_dut5 (
      .clk(clk), .rst(rst), .start(start5), .dio_in(dio_in5),
      .tm_clk(tm_clk5), .tm_stb(tm_stb5), .dio_out(dio_out5), .dio_oe(dio_oe5),
      .busy(busy5), .done(done5), .raw(raw5), .keys(keys5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Second instance sees only the pull-up when released.
   assign dio_in5 = dio_oe5 ? dio_out5 : 1'b1;

   // ---------------- TM1638 device model ----------------
   logic [31:0] dev_word = 32'h0;
   logic        dev_drive = 1'b0;
   logic        dev_bit = 1'b1;
   int          rd_idx = 0;
   int          cmd_cnt = 0;
   logic [7:0]  cmd_rx = 8'h00;

   assign dio_in = dio_oe ? dio_out : (dev_drive ? dev_bit : 1'b1);

   always @(negedge tm_stb) begin
      rd_idx  = 0;
      cmd_cnt = 0;
   end

   always @(posedge tm_stb) dev_drive = 1'b0;

   // Command bits are read on tm_clk rising edges.
   always @(posedge tm_clk) begin
      if (!tm_stb && dio_oe && cmd_cnt < 8) begin
         cmd_rx[3'(cmd_cnt)] = dio_in;
         cmd_cnt++;
      end
   end

   // Scan bits are presented shortly after each tm_clk falling edge once released.
   always @(negedge tm_clk) begin
      #1;
      if (!tm_stb && !dio_oe && rd_idx < 32) begin
         dev_drive = 1'b1;
         dev_bit   = dev_word[5'(rd_idx)];
         rd_idx++;
      end
   end

   // ---------------- timeline model ----------------
   function automatic logic [7:0] key_map(input logic [31:0] w);
      logic [7:0] k;
      for (int i = 0; i < 4; i++) begin
         k[i]     = w[8*i];
         k[i + 4] = w[8*i + 4];
      end
      return k;
   endfunction

   int          t = 0;       // 0 = idle, 1 = STB-low cycle after accept, ... TDONE = done cycle
   logic [31:0] exp_raw = 32'h0;
   logic [7:0]  exp_keys = 8'h0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         t        <= 0;
         exp_raw  <= 32'h0;
         exp_keys <= 8'h0;
      end else if (t == 0) begin
         if (start) t <= 1;
      end else if (t == TDONE) begin
         t <= 0;
      end else begin
         t <= t + 1;
         if (t == TDONE - 1) begin
            exp_raw  <= dev_word;
            exp_keys <= key_map(dev_word);
         end
      end
   end

   // Per-cycle compare of every output against the timeline.
   always @(negedge clk) begin : cmp
      logic e_stb, e_clk, e_oe, e_dout, e_busy, e_done;
      logic [31:0] e_raw;
      logic [7:0]  e_keys;
      int k;
      e_stb = 1'b1; e_clk = 1'b1; e_oe = 1'b0; e_dout = 1'b1;
      e_busy = 1'b0; e_done = 1'b0;
      e_raw = exp_raw; e_keys = exp_keys;
      if (rst) begin
         e_raw = 32'h0; e_keys = 8'h0;
      end else if (t == 1) begin
         e_stb = 1'b0; e_oe = 1'b1; e_dout = cmd_byte[0]; e_busy = 1'b1;
      end else if (t >= 2 && t <= 17) begin
         k = t - 2;
         e_stb = 1'b0; e_oe = 1'b1; e_busy = 1'b1;
         e_clk = (k % 2) != 0;
         e_dout = cmd_byte[3'(k / 2)];
      end else if (t >= 18 && t <= 17 + W) begin
         e_stb = 1'b0; e_busy = 1'b1;
      end else if (t >= 18 + W && t <= 81 + W) begin
         k = t - 18 - W;
         e_stb = 1'b0; e_busy = 1'b1;
         e_clk = (k % 2) != 0;
      end else if (t == 82 + W) begin
         e_busy = 1'b1;
      end else if (t == TDONE) begin
         e_done = 1'b1;
      end
      tests++;
      if (tm_stb !== e_stb || tm_clk !== e_clk || dio_oe !== e_oe ||
          (e_oe && dio_out !== e_dout) || busy !== e_busy || done !== e_done ||
          raw !== e_raw || keys !== e_keys) begin
         fails++;
         if (fails < 40)
            $display("FAIL cycle t=%0d got stb/clk/oe/dout/busy/done=%b%b%b%b%b%b raw=%h keys=%h expected %b%b%b%b%b%b raw=%h keys=%h",
                     t, tm_stb, tm_clk, dio_oe, dio_out, busy, done, raw, keys,
                     e_stb, e_clk, e_oe, e_dout, e_busy, e_done, e_raw, e_keys);
      end
   end

   // ---------------- directed checks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_stb"},  32'(tm_stb), 32'd1);
      check({name, "_clk"},  32'(tm_clk), 32'd1);
      check({name, "_oe"},   32'(dio_oe), 32'd0);
      check({name, "_busy"}, 32'(busy),   32'd0);
      check({name, "_done"}, 32'(done),   32'd0);
      check({name, "_raw"},  raw,         32'h0);
      check({name, "_keys"}, 32'(keys),   32'h0);
   endtask

   // Issue one start pulse and return edges from accept to done (-1 on timeout).
   task automatic run_scan(input logic [31:0] word, input int pulse_at,
                           input bit hold_chk, input logic [7:0] hold_k, output int lat);
      dev_word = word;
      start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      lat = -1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = n;
            break;
         end
         start = (n == pulse_at);
         if (hold_chk && n == 50) check("keys_hold", 32'(keys), 32'(hold_k));
      end
      start = 1'b0;
      if (lat < 0) check("scan_timeout", 32'(lat), 32'd84);
      repeat (3) @(posedge clk);
      #2;
   endtask

   int lat;
   int gap;
   int done_seen;

   initial begin
      rst = 1'b1;
      start = 1'b0;
      start5 = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1 check_reset_outputs("after_reset");
      repeat (2) @(posedge clk);
      #2;

      // Reset while idle.
      rst = 1'b1;
      #1 check_reset_outputs("rst_idle");
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #2;

      // Reset in the middle of the command byte.
      start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      repeat (6) @(posedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outputs("rst_cmd");
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #2;

      // Command byte and read decode.
      run_scan(32'h00100001, 0, 1'b0, 8'h00, lat);
      check("latency_84", 32'(lat), 32'd84);
      check("cmd_byte",   32'(cmd_rx), 32'h42);
      check("raw_decode", raw, 32'h00100001);
      check("keys_decode", 32'(keys), 32'h41);

      // All keys, then all released with values held until done.
      run_scan(32'h11111111, 0, 1'b0, 8'h00, lat);
      check("raw_all", raw, 32'h11111111);
      check("keys_all", 32'(keys), 32'hFF);
      run_scan(32'h00000000, 0, 1'b1, 8'hFF, lat);
      check("raw_none", raw, 32'h0);
      check("keys_none", 32'(keys), 32'h00);

      // Extra start pulse during a scan is ignored.
      run_scan(32'h00000010, 30, 1'b0, 8'h00, lat);
      check("latency_busy_pulse", 32'(lat), 32'd84);
      check("keys_busy_pulse", 32'(keys), 32'h10);

      // start held high: back-to-back scans.
      dev_word = 32'h11111111;
      start = 1'b1;
      gap = -1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk);
         #1;
         if (done) break;
      end
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            gap = n;
            break;
         end
      end
      check("done_gap_86", 32'(gap), 32'd86);
      #1 start = 1'b0;
      repeat (100) @(posedge clk);
      #2;
      check("keys_stuck", 32'(keys), 32'hFF);

      // Abort during READ bit 10: nothing published, then a clean scan.
      dev_word = 32'hFFFFFFFF;
      start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      repeat (40) @(posedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outputs("rst_read");
      @(posedge clk);
      #2 rst = 1'b0;
      done_seen = 0;
      for (int n = 0; n < 100; n++) begin
         @(posedge clk);
         #1;
         if (done) done_seen++;
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
      check("abort_keys", 32'(keys), 32'h0);
      #1;
      run_scan(32'h00010000, 0, 1'b0, 8'h00, lat);
      check("latency_after_abort", 32'(lat), 32'd84);
      check("keys_after_abort", 32'(keys), 32'h04);

      // WAIT_CYCLES = 5 instance.
      start5 = 1'b1;
      @(posedge clk);
      #2 start5 = 1'b0;
      lat = -1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk);
         #1;
         if (done5) begin
            lat = n;
            break;
         end
      end
      check("latency_w5_87", 32'(lat), 32'd87);
      check("raw_w5", raw5, 32'hFFFFFFFF);
      check("keys_w5", 32'(keys5), 32'hFF);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
